instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
Word-addressed instruction store for the multi-cycle processor; returns one 32-bit instruction per 16-bit word address.
- Read is combinational; the fetch stage samples read_data on its own clock edge.
- A synchronous load port lets a bench or boot loader overwrite words.
- Synchronous reset restores the default program image.

Parameters:
DEPTH, 256, number of 32-bit words (power of two, 16..65536)
AW, 16, address width of inst_address and wr_addr
DW, 32, instruction width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
inst_address  in  16  word index of the instruction to fetch (not a byte address)
read_data  out  32  instruction at inst_address
wr_en  in  1  load-port write strobe
wr_addr  in  16  load-port word index
wr_data  in  32  load-port data

Behaviour:
- Storage: array of DEPTH x 32-bit words, word-indexed; inst_address = i selects word i.
- Read, combinational:
  - read_data = mem[inst_address] when inst_address < DEPTH, else 32'h00000000.
  - No clock latency; read_data settles within the same delta/cycle after the address changes.
- Reset, synchronous, rst=1 at a rising clk edge:
  - All words are reloaded from the package constant DEFAULT_IMAGE: words 0..8 hold the program below, words 9..DEPTH-1 hold 0.
  - read_data is therefore DEFAULT_IMAGE[inst_address] from the edge after reset onward. No other state exists.
- Default program, word: value:
  - 0: 8C010000
  - 1: 8C020004
  - 2: 00221820
  - 3: 00222022
  - 4: 00222824
  - 5: 00223025
  - 6: AC030008
  - 7: 1022FFF8
  - 8: 08000000
- Power-up: the array is initialised to DEFAULT_IMAGE at time 0, so fetches before the first reset return the default program.
- Write:
  - On a rising clk with rst=0 and wr_en=1, mem[wr_addr] <= wr_data.
  - If wr_addr >= DEPTH, the write is silently dropped.
- Simultaneous rst and wr_en: reset wins and the write is discarded.
- Read-during-write at the same address: read_data shows the old word until the edge, and the new word immediately after.
- Address bits above log2(DEPTH) are compared, never truncated; no wrap-around.

Optional Feature:
INSTMEM_ADDR_CHECK_EN
- Defined:
  - Adds output addr_err (1 bit), combinational, equal to 1 when inst_address >= DEPTH.
  - Adds output wr_err (1 bit), registered: set for one cycle after a dropped out-of-range write, cleared by rst.
- Undefined: neither port exists, and out-of-range accesses behave as above with no indication.

Decomposition:
- Package instruction_memory_pkg holds:
  - DW
  - AW
  - DEFAULT_DEPTH
  - NOP_WORD (32'h00000000)
  - DEFAULT_IMAGE, the 9-entry program constant, plus a function returning the image word for any index (0 beyond 8)
- No sub-module needed; the array, reset reload, write port and read mux all live in one module.

Test Plan:
- Read after reset: pulse rst one cycle, then sweep inst_address 0..8 at 10 ns steps -> read_data = 8C010000, 8C020004, 00221820, 00222022, 00222824, 00223025, AC030008, 1022FFF8, 08000000.
- Unused and out-of-range words: inst_address=9 -> 00000000; inst_address=DEPTH -> 00000000, and addr_err=1 when the macro is defined.
- Load port: wr_en=1, wr_addr=3, wr_data=DEADBEEF for one edge; with inst_address=3, read_data = 00222022 before the edge and DEADBEEF after it.
- Reset wins: rst=1 and wr_en=1 with wr_addr=0, wr_data=12345678 on the same edge -> read_data at address 0 = 8C010000.
- Dropped write: wr_addr=DEPTH+1, wr_data=FFFFFFFF -> no word changes (sweep 0..DEPTH-1 unchanged), and wr_err pulses for one cycle when the macro is defined.
- Reset restores image: write 0000FFFF to address 8, assert rst -> address 8 reads 08000000.

Source files
------------

// File: rtl/instruction_memory_pkg.sv
// instruction_memory_pkg
//   Shared widths, the default program image and a lookup helper for the
//   word-addressed instruction store.
//   DW             : instruction width (32)
//   AW             : word-address width (16)
//   DEFAULT_DEPTH  : default number of words (256)
//   NOP_WORD       : value returned for unused / out-of-range words
//   DEFAULT_IMAGE  : 9-word boot program loaded at power-up and on reset
//   image_word()   : image word for any index, NOP_WORD beyond the program
package instruction_memory_pkg;

    localparam int DW            = 32;
    localparam int AW            = 16;
    localparam int DEFAULT_DEPTH = 256;
    localparam int IMAGE_LEN     = 9;

    localparam logic [DW-1:0] NOP_WORD = 32'h0000_0000;

    localparam logic [DW-1:0] DEFAULT_IMAGE [IMAGE_LEN] = '{
        32'h8C01_0000,  // lw  r1, 0(r0)
        32'h8C02_0004,  // lw  r2, 4(r0)
        32'h0022_1820,  // add r3, r1, r2
        32'h0022_2022,  // sub r4, r1, r2
        32'h0022_2824,  // and r5, r1, r2
        32'h0022_3025,  // or  r6, r1, r2
        32'hAC03_0008,  // sw  r3, 8(r0)
        32'h1022_FFF8,  // beq r1, r2, -8
        32'h0800_0000   // j   0
    };

    // Image word for a full-width word index; anything past the program is a NOP.
    function automatic logic [DW-1:0] image_word(input logic [AW-1:0] idx);
        logic [DW-1:0] word_v;
        if (idx < AW'(IMAGE_LEN)) begin
            word_v = DEFAULT_IMAGE[idx[3:0]];
        end else begin
            word_v = NOP_WORD;
        end
        return word_v;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// instruction_memory
//   Word-addressed instruction store with a combinational read port and a
//   synchronous load port. Synchronous active-high reset restores the default
//   program image.
//
//   The default image is held as constant ROM; a per-word "written" mask
//   selects between the ROM word and the load-port RAM word. Reset (and a
//   zeroed power-up state) clears the mask, which makes the whole array read
//   back as DEFAULT_IMAGE without having to rewrite DEPTH words.
//
// Ports:
//   clk          in   1   system clock, state updates on rising edge
//   rst          in   1   synchronous active-high reset
//   inst_address in   AW  word index to fetch
//   read_data    out  DW  instruction at inst_address (0 when out of range)
//   wr_en        in   1   load-port write strobe
//   wr_addr      in   AW  load-port word index
//   wr_data      in   DW  load-port data
//   addr_err     out  1   (INSTMEM_ADDR_CHECK_EN) inst_address >= DEPTH
//   wr_err       out  1   (INSTMEM_ADDR_CHECK_EN) one-cycle pulse after a
//                         dropped out-of-range write
//
// Build option: define INSTMEM_ADDR_CHECK_EN to add addr_err / wr_err.
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] inst_address,
    output logic [DW-1:0] read_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
`ifdef INSTMEM_ADDR_CHECK_EN
    ,
    output logic          addr_err,
    output logic          wr_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    // One extra bit so DEPTH = 65536 is representable; the full address is
    // compared against it, so high address bits never wrap into the array.
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

    logic [DW-1:0]    mem_r [DEPTH];
    logic [DEPTH-1:0] written_r;

    logic             rd_in_range_s;
    logic             wr_in_range_s;
    logic             wr_commit_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] wr_idx_s;

    assign rd_in_range_s = ({1'b0, inst_address} < DEPTH_EXT);
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_idx_s      = inst_address[IDX_W-1:0];
    assign wr_idx_s      = wr_addr[IDX_W-1:0];
    // Reset has priority over the load port.
    assign wr_commit_s   = !rst && wr_en && wr_in_range_s;

    // Written mask: reset reverts every word to the image, a write claims one.
    always_ff @(posedge clk) begin
        if (rst) begin
            written_r <= '0;
        end else if (wr_commit_s) begin
            written_r[wr_idx_s] <= 1'b1;
        end else begin
            written_r <= written_r;
        end
    end

    // Load-port RAM; contents only matter once the mask bit is set.
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            mem_r[wr_idx_s] <= wr_data;
        end
    end

    // Combinational read mux: out of range -> NOP, else RAM or image word.
    always_comb begin
        read_data = NOP_WORD;
        if (rd_in_range_s) begin
            if (written_r[rd_idx_s]) begin
                read_data = mem_r[rd_idx_s];
            end else begin
                read_data = image_word(inst_address);
            end
        end else begin
            read_data = NOP_WORD;
        end
    end

`ifdef INSTMEM_ADDR_CHECK_EN
    logic wr_err_r;

    assign addr_err = !rd_in_range_s;
    assign wr_err   = wr_err_r;

    // Flag a dropped write for exactly the cycle after it was attempted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_en && !wr_in_range_s;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic [15:0] inst_address;
    logic [31:0] read_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
`ifdef INSTMEM_ADDR_CHECK_EN
    logic        addr_err;
    logic        wr_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: plain array of words plus the expected wr_err pulse.
    logic [31:0] golden [9] = '{32'h8C010000, 32'h8C020004, 32'h00221820,
                                32'h00222022, 32'h00222824, 32'h00223025,
                                32'hAC030008, 32'h1022FFF8, 32'h08000000};
    logic [31:0] exp_mem [DEPTH];
    logic        exp_wr_err;

    instruction_memory #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_address (inst_address),
        .read_data    (read_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
`ifdef INSTMEM_ADDR_CHECK_EN
        ,
        .addr_err     (addr_err),
        .wr_err       (wr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_load_image();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = (i < 9) ? golden[i] : 32'h0;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        if (int'(a) < DEPTH) return exp_mem[int'(a)];
        return 32'h0;
    endfunction

    // One rising edge: update the model from the inputs held across it,
    // then return at the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_load_image();
            exp_wr_err = 1'b0;
        end else begin
            exp_wr_err = wr_en && (int'(wr_addr) >= DEPTH);
            if (wr_en && int'(wr_addr) < DEPTH) exp_mem[int'(wr_addr)] = wr_data;
        end
        @(negedge clk);
    endtask

    task automatic test_power_up();
        inst_address = 16'd0;
        #1;
        tests_run++;
        if (read_data !== 32'h8C010000) begin
            tests_failed++;
            $display("FAIL power_up: read_data=%h expected=%h", read_data, 32'h8C010000);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            inst_address = 16'(i);
            #1;
            tests_run++;
            if (read_data !== golden[i]) begin
                tests_failed++;
                $display("FAIL reset_image[%0d]: read_data=%h expected=%h", i, read_data, golden[i]);
            end
            step();
        end
    endtask

    task automatic test_unused_oob();
        inst_address = 16'd9;
        #1;
        tests_run++;
        if (read_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL unused_word: read_data=%h expected=00000000", read_data);
        end
        inst_address = 16'(DEPTH);
        #1;
        tests_run++;
        if (read_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL oob_read: read_data=%h expected=00000000", read_data);
        end
`ifdef INSTMEM_ADDR_CHECK_EN
        tests_run++;
        if (addr_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL addr_err_oob: addr_err=%b expected=1", addr_err);
        end
        inst_address = 16'(DEPTH - 1);
        #1;
        tests_run++;
        if (addr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL addr_err_last: addr_err=%b expected=0", addr_err);
        end
`endif
        // High address bits must not alias onto word 0.
        inst_address = 16'(DEPTH * 4);
        #1;
        tests_run++;
        if (read_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL no_wrap: read_data=%h expected=00000000", read_data);
        end
    endtask

    task automatic test_load_port();
        inst_address = 16'd3;
        wr_en = 1'b1; wr_addr = 16'd3; wr_data = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (read_data !== 32'h00222022) begin
            tests_failed++;
            $display("FAIL rdw_before: read_data=%h expected=00222022", read_data);
        end
        step();
        wr_en = 1'b0;
        #1;
        tests_run++;
        if (read_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL rdw_after: read_data=%h expected=deadbeef", read_data);
        end
    endtask

    task automatic test_reset_wins();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 16'd0; wr_data = 32'h12345678;
        step();
        rst = 1'b0; wr_en = 1'b0;
        inst_address = 16'd0;
        #1;
        tests_run++;
        if (read_data !== 32'h8C010000) begin
            tests_failed++;
            $display("FAIL reset_wins: read_data=%h expected=8c010000", read_data);
        end
        inst_address = 16'd3;
        #1;
        tests_run++;
        if (read_data !== 32'h00222022) begin
            tests_failed++;
            $display("FAIL reset_clears_load: read_data=%h expected=00222022", read_data);
        end
    endtask

    task automatic test_dropped_write();
        int bad;
        wr_en = 1'b1; wr_addr = 16'(DEPTH + 1); wr_data = 32'hFFFFFFFF;
        step();
        wr_en = 1'b0;
`ifdef INSTMEM_ADDR_CHECK_EN
        tests_run++;
        if (wr_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_err_set: wr_err=%b expected=1", wr_err);
        end
`endif
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            inst_address = 16'(i);
            #1;
            tests_run++;
            if (read_data !== model_read(16'(i))) begin
                tests_failed++;
                if (bad < 5)
                    $display("FAIL dropped_write[%0d]: read_data=%h expected=%h",
                             i, read_data, model_read(16'(i)));
                bad++;
            end
        end
        step();
`ifdef INSTMEM_ADDR_CHECK_EN
        tests_run++;
        if (wr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_err_clear: wr_err=%b expected=0", wr_err);
        end
`endif
    endtask

    task automatic test_reset_restores();
        wr_en = 1'b1; wr_addr = 16'd8; wr_data = 32'h0000FFFF;
        step();
        wr_en = 1'b0;
        inst_address = 16'd8;
        #1;
        tests_run++;
        if (read_data !== 32'h0000FFFF) begin
            tests_failed++;
            $display("FAIL write_addr8: read_data=%h expected=0000ffff", read_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if (read_data !== 32'h08000000) begin
            tests_failed++;
            $display("FAIL reset_restores: read_data=%h expected=08000000", read_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 49) == 0);
            wr_en        = ($urandom_range(0, 1) == 1);
            wr_addr      = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            wr_data      = $urandom;
            inst_address = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            #1;
            tests_run++;
            if (read_data !== model_read(inst_address)) begin
                tests_failed++;
                $display("FAIL random_read[%0d] addr=%h: read_data=%h expected=%h",
                         n, inst_address, read_data, model_read(inst_address));
            end
            step();
`ifdef INSTMEM_ADDR_CHECK_EN
            tests_run++;
            if (wr_err !== exp_wr_err) begin
                tests_failed++;
                $display("FAIL random_wr_err[%0d]: wr_err=%b expected=%b", n, wr_err, exp_wr_err);
            end
`endif
        end
        rst = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = 16'd0; wr_data = 32'd0; inst_address = 16'd0;
        exp_wr_err = 1'b0;
        model_load_image();
        test_power_up();
        test_reset();
        test_unused_oob();
        test_load_port();
        test_reset_wins();
        test_dropped_write();
        test_reset_restores();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
